// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings, branch-condition and EX-stage
// state enums, and the flag-setting opcode classifier.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SUBI = 5'b00101;
  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_ANDI = 5'b01011;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NOT  = 5'b01110;
  localparam logic [4:0] OP_XOR  = 5'b10000;
  localparam logic [4:0] OP_XORI = 5'b10001;
  localparam logic [4:0] OP_CMP  = 5'b10010;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GT = 2'b11
  } br_cond_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } ex_state_t;

  function automatic logic is_flag_setting(input logic [4:0] opcode);
    case (opcode)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV, OP_AND, OP_ANDI,
      OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI, OP_CMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluation against the Z/N flag pair
// (flags[1] = Z, flags[0] = N).
module br_cond_eval
  import cpu_pkg::*;
(
  input  logic [1:0] flags,
  input  logic [1:0] cond,
  output logic       taken
);

  logic z;
  logic n;

  assign z = flags[1];
  assign n = flags[0];

  always_comb begin
    taken = 1'b0;
    case (br_cond_t'(cond))
      BR_EQ: taken = z;
      BR_NE: taken = ~z;
      BR_LT: taken = n;
      BR_GT: taken = ~z & ~n;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_retire_stage.sv
// EX/MEM boundary: result register, Z/N flags, branch resolution and
// wrong-path squash. Optional perf counters under `EX_PERF_CNT_EN.
module ex_retire_stage
  import cpu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = 4,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [4:0]            in_opcode,
  input  logic [31:0]           in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wb_en,
  input  logic                  in_is_branch,
  input  logic [1:0]            in_br_cond,
  input  logic [31:0]           in_br_target,
  input  logic                  mem_stall,
  input  logic                  flush,
  output logic                  stall_up,
  output logic                  out_valid,
  output logic [31:0]           out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wb_en,
  output logic [1:0]            flags_q,
  output logic                  br_taken,
  output logic [31:0]           br_target
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_br_taken
`endif
);

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

  ex_state_t  state;
  ex_state_t  state_next;
  logic [2:0] sq_cnt;
  logic       cond_true;
  logic       accept;
  logic       take;
  logic       sq_dec;

  br_cond_eval u_br_cond_eval (
    .flags (flags_q),
    .cond  (in_br_cond),
    .taken (cond_true)
  );

  assign stall_up = mem_stall;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush)
      state_next = RUN;
    else if (state == RUN && take)
      state_next = SQUASH;
    else if (state == SQUASH && !mem_stall && sq_cnt == 3'd1)
      state_next = RUN;
  end

  always_comb begin
    accept = in_valid & ~mem_stall & (state == RUN) & ~flush;
    take   = accept & in_is_branch & cond_true;
    sq_dec = (state == SQUASH) & ~mem_stall & ~flush;
  end

  // Flags are sampled by the branch evaluator before this edge, so a CMP
  // immediately followed by a branch resolves without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_wb_en  <= 1'b0;
      flags_q    <= 2'b00;
      br_taken   <= 1'b0;
      br_target  <= '0;
      sq_cnt     <= '0;
    end else begin
      br_taken <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
        sq_cnt    <= '0;
      end else if (!mem_stall) begin
        out_valid <= accept;
        if (accept) begin
          out_result <= in_result;
          out_rd     <= in_rd;
          out_wb_en  <= in_wb_en & ~in_is_branch & (in_opcode != OP_CMP);
          if (!in_is_branch && is_flag_setting(in_opcode))
            flags_q <= {in_result == '0, in_result[31]};
          if (take) begin
            br_taken  <= 1'b1;
            br_target <= in_br_target;
            sq_cnt    <= SQ_LOAD;
          end
        end
        if (sq_dec)
          sq_cnt <= sq_cnt - 3'd1;
      end
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired  <= '0;
      perf_br_taken <= '0;
    end else begin
      if (accept && perf_retired != '1)
        perf_retired <= perf_retired + 32'd1;
      if (take && perf_br_taken != '1)
        perf_br_taken <= perf_br_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_retire_stage.sv
// Directed bench for ex_retire_stage: expected outputs are queued when each
// instruction is driven and compared one cycle later.
module tb_ex_retire_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [31:0] in_result;
  logic [3:0]  in_rd;
  logic        in_wb_en;
  logic        in_is_branch;
  logic [1:0]  in_br_cond;
  logic [31:0] in_br_target;
  logic        mem_stall;
  logic        flush;
  logic        stall_up;
  logic        out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wb_en;
  logic [1:0]  flags_q;
  logic        br_taken;
  logic [31:0] br_target;
`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_br_taken;
`endif

  typedef struct {
    logic        su;
    logic        v;
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wb;
    logic [1:0]  fl;
    logic        bt;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] ADD = 5'b00010;
  localparam logic [4:0] CMP = 5'b10010;
  localparam logic [4:0] XOR = 5'b10000;
  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] BRC = 5'b11000;

  ex_retire_stage #(.REG_ADDR_W(4), .SQUASH_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_opcode    (in_opcode),
    .in_result    (in_result),
    .in_rd        (in_rd),
    .in_wb_en     (in_wb_en),
    .in_is_branch (in_is_branch),
    .in_br_cond   (in_br_cond),
    .in_br_target (in_br_target),
    .mem_stall    (mem_stall),
    .flush        (flush),
    .stall_up     (stall_up),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .flags_q      (flags_q),
    .br_taken     (br_taken),
    .br_target    (br_target)
`ifdef EX_PERF_CNT_EN
    ,
    .perf_retired  (perf_retired),
    .perf_br_taken (perf_br_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int step, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL step%0d %s observed %h expected %h", step, tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs (at negedge) and queue what the outputs must be after the edge.
  task automatic drive(input logic r, input logic fl_in, input logic st, input logic v,
                       input logic [4:0] op, input logic [31:0] res, input logic [3:0] rd,
                       input logic wb, input logic br, input logic [1:0] cond,
                       input logic [31:0] tgt, input exp_t e);
    @(negedge clk);
    rst = r; flush = fl_in; mem_stall = st; in_valid = v; in_opcode = op;
    in_result = res; in_rd = rd; in_wb_en = wb; in_is_branch = br;
    in_br_cond = cond; in_br_target = tgt;
    exp_q.push_back(e);
  endtask

  task automatic sample(input int step);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL step%0d scoreboard observed empty expected entry", step);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall_up",   step, {31'd0, stall_up},  {31'd0, e.su});
      chk("out_valid",  step, {31'd0, out_valid}, {31'd0, e.v});
      chk("out_result", step, out_result,         e.res);
      chk("out_rd",     step, {28'd0, out_rd},    {28'd0, e.rd});
      chk("out_wb_en",  step, {31'd0, out_wb_en}, {31'd0, e.wb});
      chk("flags_q",    step, {30'd0, flags_q},   {30'd0, e.fl});
      chk("br_taken",   step, {31'd0, br_taken},  {31'd0, e.bt});
      chk("br_target",  step, br_target,          e.tgt);
    end
  endtask

  function automatic exp_t E(input logic su, input logic v, input logic [31:0] res,
                             input logic [3:0] rd, input logic wb, input logic [1:0] fl,
                             input logic bt, input logic [31:0] tgt);
    exp_t e;
    e.su = su; e.v = v; e.res = res; e.rd = rd; e.wb = wb; e.fl = fl; e.bt = bt; e.tgt = tgt;
    return e;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0; in_valid = 1'b0; in_opcode = '0;
    in_result = '0; in_rd = '0; in_wb_en = 1'b0; in_is_branch = 1'b0;
    in_br_cond = '0; in_br_target = '0;

    // reset
    drive(1,0,0,0, NOP, 32'h0,  4'd0, 0,0,2'b00, 32'h0,   E(0,0,32'h0,4'd0,0,2'b00,0,32'h0));   sample(0);
    // ADD result 0 sets Z
    drive(0,0,0,1, ADD, 32'h0,  4'd3, 1,0,2'b00, 32'h0,   E(0,1,32'h0,4'd3,1,2'b10,0,32'h0));   sample(1);
    // CMP negative -> N, no writeback
    drive(0,0,0,1, CMP, 32'hFFFF_FFFE, 4'd5, 1,0,2'b00, 32'h0, E(0,1,32'hFFFF_FFFE,4'd5,0,2'b01,0,32'h0)); sample(2);
    // BLT taken back-to-back with CMP
    drive(0,0,0,1, BRC, 32'h7,  4'd6, 1,1,2'b10, 32'h100, E(0,1,32'h7,4'd6,0,2'b01,1,32'h100)); sample(3);
    // two squashed slots
    drive(0,0,0,1, ADD, 32'h1,  4'd1, 1,0,2'b00, 32'h0,   E(0,0,32'h7,4'd6,0,2'b01,0,32'h100)); sample(4);
    drive(0,0,0,1, ADD, 32'h2,  4'd2, 1,0,2'b00, 32'h0,   E(0,0,32'h7,4'd6,0,2'b01,0,32'h100)); sample(5);
    // third accepted
    drive(0,0,0,1, ADD, 32'h3,  4'd7, 1,0,2'b00, 32'h0,   E(0,1,32'h3,4'd7,1,2'b00,0,32'h100)); sample(6);
    // BEQ with Z=0: not taken, no-op bubble
    drive(0,0,0,1, BRC, 32'h55, 4'd8, 1,1,2'b00, 32'h200, E(0,1,32'h55,4'd8,0,2'b00,0,32'h100)); sample(7);
    // no squash after untaken branch; XOR sets N
    drive(0,0,0,1, XOR, 32'h8000_0000, 4'd9, 1,0,2'b00, 32'h0, E(0,1,32'h8000_0000,4'd9,1,2'b01,0,32'h100)); sample(8);
    // idle bubble
    drive(0,0,0,0, ADD, 32'h0,  4'd0, 0,0,2'b00, 32'h0,   E(0,0,32'h8000_0000,4'd9,1,2'b01,0,32'h100)); sample(9);
    // ADD then 3 stalled cycles
    drive(0,0,0,1, ADD, 32'h0,  4'd4, 1,0,2'b00, 32'h0,   E(0,1,32'h0,4'd4,1,2'b10,0,32'h100)); sample(10);
    for (int i = 0; i < 3; i++) begin
      drive(0,0,1,1, ADD, 32'h1234, 4'd10, 1,0,2'b00, 32'h0, E(1,1,32'h0,4'd4,1,2'b10,0,32'h100)); sample(11 + i);
    end
    drive(0,0,0,1, ADD, 32'h1234, 4'd10, 1,0,2'b00, 32'h0, E(0,1,32'h1234,4'd10,1,2'b00,0,32'h100)); sample(14);
    // taken BEQ then flush during squash
    drive(0,0,0,1, CMP, 32'h0,  4'd0, 0,0,2'b00, 32'h0,   E(0,1,32'h0,4'd0,0,2'b10,0,32'h100)); sample(15);
    drive(0,0,0,1, BRC, 32'h9,  4'd1, 1,1,2'b00, 32'h300, E(0,1,32'h9,4'd1,0,2'b10,1,32'h300)); sample(16);
    drive(0,1,0,1, ADD, 32'h77, 4'd2, 1,0,2'b00, 32'h0,   E(0,0,32'h9,4'd1,0,2'b10,0,32'h300)); sample(17);
    drive(0,0,0,1, ADD, 32'h42, 4'd2, 1,0,2'b00, 32'h0,   E(0,1,32'h42,4'd2,1,2'b00,0,32'h300)); sample(18);
    // BGT taken, then reset mid-squash
    drive(0,0,0,1, BRC, 32'hA,  4'd3, 1,1,2'b11, 32'h400, E(0,1,32'hA,4'd3,0,2'b00,1,32'h400)); sample(19);
    drive(1,0,0,1, ADD, 32'h5,  4'd5, 1,0,2'b00, 32'h0,   E(0,0,32'h0,4'd0,0,2'b00,0,32'h0));   sample(20);
    drive(0,0,0,1, ADD, 32'h5,  4'd5, 1,0,2'b00, 32'h0,   E(0,1,32'h5,4'd5,1,2'b00,0,32'h0));   sample(21);
    // non-flag-setting opcode with zero result leaves flags alone
    drive(0,0,0,1, NOP, 32'h0,  4'd6, 1,0,2'b00, 32'h0,   E(0,1,32'h0,4'd6,1,2'b00,0,32'h0));   sample(22);
    // BNE taken, stall inside squash must freeze the counter
    drive(0,0,0,1, CMP, 32'h10, 4'd0, 0,0,2'b00, 32'h0,   E(0,1,32'h10,4'd0,0,2'b00,0,32'h0));  sample(23);
    drive(0,0,0,1, BRC, 32'hB,  4'd1, 1,1,2'b01, 32'h500, E(0,1,32'hB,4'd1,0,2'b00,1,32'h500)); sample(24);
    drive(0,0,1,1, ADD, 32'h1,  4'd2, 1,0,2'b00, 32'h0,   E(1,1,32'hB,4'd1,0,2'b00,0,32'h500)); sample(25);
    drive(0,0,0,1, ADD, 32'h1,  4'd2, 1,0,2'b00, 32'h0,   E(0,0,32'hB,4'd1,0,2'b00,0,32'h500)); sample(26);
    drive(0,0,0,1, ADD, 32'h1,  4'd2, 1,0,2'b00, 32'h0,   E(0,0,32'hB,4'd1,0,2'b00,0,32'h500)); sample(27);
    drive(0,0,0,1, ADD, 32'h66, 4'd2, 1,0,2'b00, 32'h0,   E(0,1,32'h66,4'd2,1,2'b00,0,32'h500)); sample(28);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
